// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between an upstream stage, the skid buffer and the downstream stage.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface pipe_stage_buf_if #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 137
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages, updated on the falling clock edge.
// in_ready depends only on registered state; flush squashes held words and counts them.
module pipe_stage_buf #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 137,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_buf_if.slave  bus,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [DATA_W-1:0] r_s_data;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [1:0] w_state_nxt;
    logic       w_out_valid;
    logic       w_in_ready;
    logic       w_in_xfer;
    logic       w_out_xfer;
    logic       w_m_ld_in;
    logic       w_m_ld_s;
    logic       w_s_ld;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_ready  = (r_state != ST_FULL);
    assign w_in_xfer   = bus.in_valid & w_in_ready;
    assign w_out_xfer  = w_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_ctrl  = w_out_valid ? r_m_ctrl : '0;
    assign bus.out_data  = r_m_data;
    assign occupancy     = r_state;
    assign flush_cnt     = r_flush_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_m_ld_in   = 1'b0;
        w_m_ld_s    = 1'b0;
        w_s_ld      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_HALF;
                        w_m_ld_in   = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_s_ld      = 1'b1;
                    end else if (w_in_xfer && w_out_xfer) begin
                        w_m_ld_in   = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_state_nxt = ST_HALF;
                        w_m_ld_s    = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Falling-edge state update; flush leaves M's data in place so out_data holds.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_m_ctrl    <= '0;
            r_m_data    <= '0;
            r_s_ctrl    <= '0;
            r_s_data    <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_m_ld_in) begin
                r_m_ctrl <= bus.in_ctrl;
                r_m_data <= bus.in_data;
            end else if (w_m_ld_s) begin
                r_m_ctrl <= r_s_ctrl;
                r_m_data <= r_s_data;
            end
            if (w_s_ld) begin
                r_s_ctrl <= bus.in_ctrl;
                r_s_data <= bus.in_data;
            end
            if (flush) begin
                r_flush_cnt <= sat_add(r_flush_cnt, r_state);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a driver queues accepted words, a monitor pops and
// compares each delivered word; a CNT_W=2 twin shares the stimulus for saturation checks.
module tb_pipe_stage_buf;

    localparam int CW = 10;
    localparam int DW = 137;

    typedef logic [CW+DW-1:0] word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  occ;
    logic [1:0]  occ_s;
    logic [15:0] fcnt;
    logic [1:0]  fcnt_s;

    word_t q[$];
    int    total = 0;
    int    bad   = 0;

    pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) dif ();
    pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) sif ();

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (dif.slave),
        .flush     (flush),
        .occupancy (occ),
        .flush_cnt (fcnt)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (sif.slave),
        .flush     (flush),
        .occupancy (occ_s),
        .flush_cnt (fcnt_s)
    );

    assign sif.in_valid  = dif.in_valid;
    assign sif.in_ctrl   = dif.in_ctrl;
    assign sif.in_data   = dif.in_data;
    assign sif.out_ready = dif.out_ready;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(input logic [7:0] k);
        return {1'b1, {17{k}}};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic idle();
        dif.in_valid = 1'b0;
    endtask

    // Presents a word and waits (bounded) for its acceptance edge; leaves in_valid high.
    task automatic send(input logic [CW-1:0] c);
        bit acc;
        acc = 1'b0;
        dif.in_ctrl  = c;
        dif.in_data  = mkdata(c[7:0]);
        dif.in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(posedge clk);
            if (dif.in_ready && !flush) begin
                q.push_back({c, mkdata(c[7:0])});
                acc = 1'b1;
            end
            @(negedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %0h not accepted within 50 cycles", c);
        end
    endtask

    task automatic flush_full(input logic [CW-1:0] c1, input logic [CW-1:0] c2, input bit inc,
                              input logic [15:0] exp_main, input logic [1:0] exp_sat);
        dif.out_ready = 1'b0;
        send(c1);
        send(c2);
        if (inc) begin
            dif.in_ctrl  = 10'h3FF;
            dif.in_data  = mkdata(8'hFF);
            dif.in_valid = 1'b1;
        end else begin
            idle();
        end
        chk("pre_flush_occ", occ, 2'd2);
        flush = 1'b1;
        @(negedge clk);
        #1;
        q.delete();
        flush = 1'b0;
        idle();
        chk("flush_occ", occ, 2'd0);
        chk("flush_out_ctrl", dif.out_ctrl, '0);
        chk("flush_cnt", fcnt, exp_main);
        chk("flush_cnt_sat", fcnt_s, exp_sat);
        cyc(2);
        chk("flush_no_output", dif.out_valid, 1'b0);
    endtask

    // Scoreboard monitor: a word is delivered at the falling edge following this sample.
    always @(posedge clk) begin
        if (rst_n && dif.out_valid && dif.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got ctrl %0h with nothing expected", dif.out_ctrl);
            end else begin
                chk("out_word", {dif.out_ctrl, dif.out_data}, q[0]);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.in_valid  = 1'b0;
        dif.in_ctrl   = '0;
        dif.in_data   = '0;
        dif.out_ready = 1'b0;
        #1;
        chk("rst_occ", occ, 2'd0);
        chk("rst_in_ready", dif.in_ready, 1'b1);
        chk("rst_out_valid", dif.out_valid, 1'b0);
        chk("rst_out_ctrl", dif.out_ctrl, '0);
        chk("rst_out_data", dif.out_data, '0);
        chk("rst_flush_cnt", fcnt, '0);
        #2;
        rst_n = 1'b1;

        // Streaming, one word per cycle, one edge latency
        dif.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(CW'(i));
            chk("stream_latency", dif.out_ctrl, CW'(i));
            chk("stream_occ", occ, 2'd1);
        end
        idle();
        cyc(1);
        chk("drain_occ", occ, 2'd0);
        chk("bubble_ctrl", dif.out_ctrl, '0);
        chk("hold_data", dif.out_data, mkdata(8'd10));
        chk("drain_queue", q.size(), 0);

        // Stall fill
        dif.out_ready = 1'b0;
        send(10'h0A1);
        send(10'h0B2);
        dif.in_ctrl = 10'h0C3;
        dif.in_data = mkdata(8'hC3);
        cyc(3);
        chk("stall_occ", occ, 2'd2);
        chk("stall_in_ready", dif.in_ready, 1'b0);
        chk("stall_head", dif.out_ctrl, 10'h0A1);
        chk("stall_twin_occ", occ_s, occ);
        dif.out_ready = 1'b1;
        send(10'h0C3);
        idle();
        cyc(2);
        chk("stall_drain_occ", occ, 2'd0);

        // Flushes in FULL, then saturation of the 2-bit twin
        flush_full(10'h0D1, 10'h0E2, 1'b1, 16'd2, 2'd2);
        flush_full(10'h0F3, 10'h104, 1'b0, 16'd4, 2'd3);
        flush_full(10'h115, 10'h126, 1'b1, 16'd6, 2'd3);

        // Flush in HALF with a simultaneous delivery
        dif.out_ready = 1'b0;
        send(10'h137);
        idle();
        chk("half_occ", occ, 2'd1);
        dif.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        #1;
        q.delete();
        flush = 1'b0;
        chk("half_flush_cnt", fcnt, 16'd7);
        chk("half_flush_cnt_sat", fcnt_s, 2'd3);
        chk("half_flush_occ", occ, 2'd0);

        // Asynchronous reset while FULL
        dif.out_ready = 1'b0;
        send(10'h148);
        send(10'h159);
        idle();
        chk("pre_reset_occ", occ, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_occ", occ, 2'd0);
        chk("arst_out_valid", dif.out_valid, 1'b0);
        chk("arst_out_ctrl", dif.out_ctrl, '0);
        chk("arst_out_data", dif.out_data, '0);
        chk("arst_flush_cnt", fcnt, '0);
        chk("arst_flush_cnt_sat", fcnt_s, '0);
        chk("arst_in_ready", dif.in_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        cyc(1);

        dif.out_ready = 1'b1;
        send(10'h16A);
        chk("post_reset_out", dif.out_ctrl, 10'h16A);
        idle();
        cyc(2);
        chk("final_queue", q.size(), 0);
        chk("final_occ", occ, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
